// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_BITS payload (LSB first), parity bit, stop bit.
// The serial line is registered and idles high; parity polarity is chosen per frame.
module parity_frame_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_odd,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state, state_d;
  logic [DATA_BITS-1:0] shift_reg, shift_d;
  logic                 parity_bit, parity_d;
  logic [BAUD_W-1:0]    baud_cnt, baud_d;
  logic [BIT_W-1:0]     bit_cnt, bit_d;
  logic                 serial_d;
  logic                 baud_tc;
  logic                 bit_tc;

  assign baud_tc  = (baud_cnt == BAUD_LAST);
  assign bit_tc   = (bit_cnt == BIT_LAST);
  assign tx_busy  = (state != IDLE);
  assign tx_ready = (state == IDLE) && !wb_rst_i;
  assign tx_done  = (state == STOP) && baud_tc;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state;
    shift_d  = shift_reg;
    parity_d = parity_bit;
    baud_d   = baud_cnt;
    bit_d    = bit_cnt;

    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          state_d  = START;
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ parity_odd;
          baud_d   = '0;
          bit_d    = '0;
        end
      end
      START: begin
        if (baud_tc) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_d  = '0;
          shift_d = shift_reg >> 1;
          if (bit_tc) begin
            state_d = PARITY;
            bit_d   = '0;
          end else begin
            bit_d = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_d = baud_cnt + BAUD_W'(1);
        end
      end
      PARITY: begin
        if (baud_tc) begin
          state_d = STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_tc) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_cnt + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is computed from the next state so the registered output
  // lines up with the state it belongs to, with no input-to-output path.
  always_comb begin
    serial_d = 1'b1;
    unique case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      PARITY:  serial_d = parity_d;
      default: serial_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx_serial  <= 1'b1;
    end else begin
      state      <= state_d;
      shift_reg  <= shift_d;
      parity_bit <= parity_d;
      baud_cnt   <= baud_d;
      bit_cnt    <= bit_d;
      tx_serial  <= serial_d;
    end
  end

endmodule
